// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundle between the MEM stage, the divide unit and the regfile write port.
// Signals: mem_we/mem_waddr/mem_wdata (MEM-stage write), stall_mem/stall_wb/flush (pipeline control),
//   div_valid/div_waddr/div_wdata/div_ready (divide result handshake),
//   rf_we/rf_waddr/rf_wdata (regfile write port), pend_cnt (occupied pending entries).
// Modports: slave = the write-back arbiter, master = the surrounding pipeline driving it.
interface wb_arbiter_if #(
    parameter int DEPTH = 2,
    parameter int AW = 5,
    parameter int DW = 32
) ();
    logic                   mem_we;
    logic [AW-1:0]          mem_waddr;
    logic [DW-1:0]          mem_wdata;
    logic                   stall_mem;
    logic                   stall_wb;
    logic                   flush;
    logic                   div_valid;
    logic [AW-1:0]          div_waddr;
    logic [DW-1:0]          div_wdata;
    logic                   div_ready;
    logic                   rf_we;
    logic [AW-1:0]          rf_waddr;
    logic [DW-1:0]          rf_wdata;
    logic [$clog2(DEPTH):0] pend_cnt;
    modport slave (
        input  mem_we, mem_waddr, mem_wdata, stall_mem, stall_wb, flush,
        input  div_valid, div_waddr, div_wdata,
        output div_ready, rf_we, rf_waddr, rf_wdata, pend_cnt
    );
    modport master (
        output mem_we, mem_waddr, mem_wdata, stall_mem, stall_wb, flush,
        output div_valid, div_waddr, div_wdata,
        input  div_ready, rf_we, rf_waddr, rf_wdata, pend_cnt
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back stage merging the MEM/WB slot with buffered divide results onto one regfile port.
// Ports: clk; rst (async, active-high); bus (wb_arbiter_if.slave) carrying the MEM-stage write,
//   pipeline controls, the divide result handshake, the regfile write port and pend_cnt.
module wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW = 5,
    parameter int DW = 32
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    logic          slot_we_q, slot_we_d;
    logic [AW-1:0] slot_waddr_q, slot_waddr_d;
    logic [DW-1:0] slot_wdata_q, slot_wdata_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] val_q, val_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic slot_wr, empty, full, head_v, store, pop, clear, latch;

    always_comb begin
        slot_wr = slot_we_q && (slot_waddr_q != '0);
        empty   = cnt_q == '0;
        full    = cnt_q == (PW+1)'(DEPTH);
        head_v  = !empty && val_q[rd_ptr_q];
        // r0 results are accepted but never occupy an entry
        store   = bus.div_valid && !full && (bus.div_waddr != '0);
        // an invalid head is dropped even while the slot owns the port
        pop     = !empty && (!slot_wr || !val_q[rd_ptr_q]);
        clear   = bus.flush || (bus.stall_mem && !bus.stall_wb);
        latch   = !bus.flush && !bus.stall_wb && !bus.stall_mem;
    end

    assign bus.div_ready = !full;
    assign bus.pend_cnt  = cnt_q;
    assign bus.rf_we     = slot_wr || head_v;
    assign bus.rf_waddr  = slot_wr ? slot_waddr_q : head_v ? addr_q[rd_ptr_q] : '0;
    assign bus.rf_wdata  = slot_wr ? slot_wdata_q : head_v ? data_q[rd_ptr_q] : '0;

    always_comb begin
        slot_we_d    = clear ? 1'b0 : latch ? bus.mem_we    : slot_we_q;
        slot_waddr_d = clear ? '0   : latch ? bus.mem_waddr : slot_waddr_q;
        slot_wdata_d = clear ? '0   : latch ? bus.mem_wdata : slot_wdata_q;
    end

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        val_d  = val_q;
        // younger slot write supersedes any buffered result for the same register
        for (int i = 0; i < DEPTH; i++)
            if (slot_wr && addr_q[i] == slot_waddr_q) val_d[i] = 1'b0;
        if (store) begin
            addr_d[wr_ptr_q] = bus.div_waddr;
            data_d[wr_ptr_q] = bus.div_wdata;
            val_d[wr_ptr_q]  = !(slot_wr && bus.div_waddr == slot_waddr_q);
        end
        wr_ptr_d = wr_ptr_q + PW'(store);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q + (PW+1)'(store) - (PW+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_we_q    <= 1'b0;
            slot_waddr_q <= '0;
            slot_wdata_q <= '0;
            val_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            slot_we_q    <= slot_we_d;
            slot_waddr_q <= slot_waddr_d;
            slot_wdata_q <= slot_wdata_d;
            val_q        <= val_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized and directed checks of wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_errors = 0;

    wb_arbiter_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();
    wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            v;
    } ent_t;

    ent_t          q[$];
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] dut_rf [32];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_we = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        q.delete();
    endtask

    task automatic check_outputs();
        bit sw, hv;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        sw = m_we && m_waddr != 0;
        hv = q.size() > 0 && q[0].v;
        ea = '0;
        ed = '0;
        if (sw) begin
            ea = m_waddr;
            ed = m_wdata;
        end else if (hv) begin
            ea = q[0].a;
            ed = q[0].d;
        end
        check("rf_we", 64'(bus.rf_we), 64'(sw || hv));
        check("rf_waddr", 64'(bus.rf_waddr), 64'(ea));
        check("rf_wdata", 64'(bus.rf_wdata), 64'(ed));
        check("div_ready", 64'(bus.div_ready), 64'(q.size() < DEPTH));
        check("pend_cnt", 64'(bus.pend_cnt), 64'(q.size()));
        if (bus.rf_we) dut_rf[bus.rf_waddr] = bus.rf_wdata;
    endtask

    task automatic model_update();
        bit sw, pop, push;
        ent_t e;
        sw = m_we && m_waddr != 0;
        pop = q.size() > 0 && (!sw || !q[0].v);
        push = bus.div_valid && q.size() < DEPTH;
        foreach (q[i]) if (sw && q[i].a == m_waddr) q[i].v = 1'b0;
        if (pop) q.delete(0);
        if (push && bus.div_waddr != 0) begin
            e.a = bus.div_waddr;
            e.d = bus.div_wdata;
            e.v = !(sw && bus.div_waddr == m_waddr);
            q.push_back(e);
        end
        if (bus.flush || (bus.stall_mem && !bus.stall_wb)) begin
            m_we = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else if (!bus.stall_wb) begin
            m_we = bus.mem_we;
            m_waddr = bus.mem_waddr;
            m_wdata = bus.mem_wdata;
        end
    endtask

    task automatic set_in(input bit mwe, input int ma, input int md, input bit sm, input bit sw,
                          input bit fl, input bit dv, input int da, input int dd);
        bus.mem_we = mwe;
        bus.mem_waddr = AW'(ma);
        bus.mem_wdata = DW'(md);
        bus.stall_mem = sm;
        bus.stall_wb = sw;
        bus.flush = fl;
        bus.div_valid = dv;
        bus.div_waddr = AW'(da);
        bus.div_wdata = DW'(dd);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) dut_rf[i] = '0;
        idle();
        model_reset();
        #12;
        check("rst_we", 64'(bus.rf_we), 64'd0);
        check("rst_waddr", 64'(bus.rf_waddr), 64'd0);
        check("rst_wdata", 64'(bus.rf_wdata), 64'd0);
        check("rst_ready", 64'(bus.div_ready), 64'd1);
        check("rst_cnt", 64'(bus.pend_cnt), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();

        set_in(1, 3, 'h1234, 0, 0, 0, 0, 0, 0);
        step();
        check("pipe_we", 64'(bus.rf_we), 64'd1);
        check("pipe_waddr", 64'(bus.rf_waddr), 64'd3);
        check("pipe_wdata", 64'(bus.rf_wdata), 64'h1234);
        set_in(1, 0, 'h55, 0, 0, 0, 0, 0, 0);
        step();
        check("r0_we", 64'(bus.rf_we), 64'd0);

        set_in(1, 1, 1, 0, 0, 0, 1, 5, 'hA);
        step();
        set_in(1, 2, 2, 0, 0, 0, 1, 6, 'hB);
        step();
        set_in(1, 3, 3, 0, 0, 0, 0, 0, 0);
        step();
        check("drain_cnt2", 64'(bus.pend_cnt), 64'd2);
        check("drain_full", 64'(bus.div_ready), 64'd0);
        idle();
        step();
        check("drain_a_addr", 64'(bus.rf_waddr), 64'd5);
        check("drain_a_data", 64'(bus.rf_wdata), 64'hA);
        step();
        check("drain_b_addr", 64'(bus.rf_waddr), 64'd6);
        check("drain_b_data", 64'(bus.rf_wdata), 64'hB);
        step();
        check("drain_cnt0", 64'(bus.pend_cnt), 64'd0);

        set_in(1, 8, 'h88, 0, 0, 0, 1, 7, 'h11);
        step();
        set_in(1, 7, 'h22, 0, 0, 0, 0, 0, 0);
        step();
        check("cancel_slot", 64'(bus.rf_wdata), 64'h22);
        idle();
        step();
        check("cancel_we", 64'(bus.rf_we), 64'd0);
        check("cancel_cnt1", 64'(bus.pend_cnt), 64'd1);
        step();
        check("cancel_cnt0", 64'(bus.pend_cnt), 64'd0);
        check("cancel_r7", 64'(dut_rf[7]), 64'h22);

        set_in(1, 9, 9, 0, 0, 0, 1, 10, 'h10);
        step();
        set_in(1, 11, 11, 1, 0, 0, 0, 0, 0);
        step();
        check("bubble_head", 64'(bus.rf_waddr), 64'd10);
        set_in(1, 12, 'h12, 0, 0, 0, 0, 0, 0);
        step();
        set_in(1, 13, 13, 0, 1, 0, 0, 0, 0);
        step();
        check("hold1", 64'(bus.rf_waddr), 64'd12);
        step();
        check("hold2", 64'(bus.rf_wdata), 64'h12);
        set_in(1, 13, 'h13, 0, 0, 0, 1, 14, 'h14);
        step();
        set_in(1, 15, 15, 0, 0, 1, 0, 0, 0);
        step();
        check("flush_cnt", 64'(bus.pend_cnt), 64'd1);
        check("flush_head", 64'(bus.rf_waddr), 64'd14);
        idle();
        step();

        for (int i = 0; i < 10; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 16 + i, 'h100 + i);
            step();
        end
        idle();
        step();
        step();
        for (int i = 0; i < 10; i++) check($sformatf("wrap_r%0d", 16 + i), 64'(dut_rf[16 + i]), 64'('h100 + i));

        set_in(1, 1, 1, 0, 0, 0, 1, 20, 'h20);
        step();
        set_in(1, 2, 2, 0, 0, 0, 1, 21, 'h21);
        step();
        set_in(0, 0, 0, 0, 0, 0, 1, 22, 'h22);
        step();
        check("full_cnt", 64'(bus.pend_cnt), 64'd2);
        step();
        check("full_pop_nopush", 64'(bus.pend_cnt), 64'd1);
        idle();
        step();

        set_in(1, 1, 1, 0, 0, 0, 1, 3, 'h33);
        step();
        set_in(1, 2, 2, 0, 0, 0, 1, 4, 'h44);
        step();
        check("pre_rst_cnt", 64'(bus.pend_cnt), 64'd2);
        #2 rst = 1'b1;
        #1;
        check("arst_we", 64'(bus.rf_we), 64'd0);
        check("arst_cnt", 64'(bus.pend_cnt), 64'd0);
        check("arst_ready", 64'(bus.div_ready), 64'd1);
        model_reset();
        idle();
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();

        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
